// File: rtl/polar_8_4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : polar_8_4_pkg
//  Description : Shared definitions for the (N=8,K=4) polar encoder/decoder
//                pair: code dimensions, frozen/info index sets, FSM states
//                and the info-bit placement helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package polar_8_4_pkg;

    localparam int N     = 8;
    localparam int K     = 4;
    localparam int LOG2N = 3;

    // Bit i set means u[i] is frozen to zero.
    localparam logic [N-1:0] FROZEN_MASK = 8'b0001_0111;

    // Info positions packed 3 bits each, entry k holds the u index for info[k].
    localparam logic [3*K-1:0] INFO_IDX = {3'd7, 3'd6, 3'd5, 3'd3};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ENC   = 2'd2,
        ST_VALID = 2'd3
    } enc_state_t;

    // Scatter the K info bits into an N-bit u vector; frozen positions stay 0.
    function automatic logic [N-1:0] map_info(input logic [K-1:0] info);
        logic [N-1:0] u;
        u = '0;
        for (int k = 0; k < K; k++) begin
            u[INFO_IDX[3*k +: 3]] = info[k];
        end
        return u;
    endfunction

endpackage
`default_nettype wire

// File: rtl/polar_xor_stage.sv
`default_nettype none
// ============================================================================
//  Module      : polar_xor_stage
//  Description : Combinational single butterfly stage of the polar transform.
//                Span d = 1<<i_stage: for every j whose bit i_stage is 0,
//                o_v[j] = i_v[j] ^ i_v[j+d]; all other bits pass through.
//  Ports       : i_stage [1:0]  stage select (0..LOG2N-1; other codes pass)
//                i_v     [N-1:0] input vector
//                o_v     [N-1:0] vector after the selected stage
//  Revision    : 1.0 - initial release
// ============================================================================
module polar_xor_stage
    import polar_8_4_pkg::*;
(
    input  logic [1:0]   i_stage,
    input  logic [N-1:0] i_v,
    output logic [N-1:0] o_v
);

    // One candidate result per stage, built structurally, then selected.
    logic [N-1:0] w_cand [LOG2N];

    genvar s, j;
    generate
        for (s = 0; s < LOG2N; s++) begin : g_stage
            for (j = 0; j < N; j++) begin : g_bit
                if (((j >> s) & 1) == 1) begin : g_pass
                    assign w_cand[s][j] = i_v[j];
                end else begin : g_xor
                    assign w_cand[s][j] = i_v[j] ^ i_v[j + (1 << s)];
                end
            end
        end
    endgenerate

    always_comb begin
        o_v = i_v;
        case (i_stage)
            2'd0:    o_v = w_cand[0];
            2'd1:    o_v = w_cand[1];
            2'd2:    o_v = w_cand[2];
            default: o_v = i_v;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/polar_enc_8_4.sv
`default_nettype none
// ============================================================================
//  Module      : polar_enc_8_4
//  Description : (8,4) polar encoder with channel flip mask and noiseless
//                LLR mapper. Encodes one butterfly stage per cycle
//                (stage 0,1,2), then holds codeword and LLRs until the
//                consumer handshakes.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                start               request, sampled only when idle
//                info[3:0]           info bits -> u3,u5,u6,u7
//                err_mask[7:0]       flip mask applied to the LLRs only
//                out_ready           consumer accepts result
//                en_busy             accepted start .. handshake done
//                out_valid           outputs valid and stable
//                code_out[7:0]       clean codeword, bit j = x_j
//                LLR_1..LLR_8        +/-LLR_MAG per (masked) codeword bit
//  Revision    : 1.0 - initial release
// ============================================================================
module polar_enc_8_4
    import polar_8_4_pkg::*;
#(
    parameter int BIT     = 8,
    parameter int LLR_MAG = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [K-1:0]   info,
    input  logic [N-1:0]   err_mask,
    input  logic           out_ready,
    output logic           en_busy,
    output logic           out_valid,
    output logic [N-1:0]   code_out,
    output logic [BIT-1:0] LLR_1,
    output logic [BIT-1:0] LLR_2,
    output logic [BIT-1:0] LLR_3,
    output logic [BIT-1:0] LLR_4,
    output logic [BIT-1:0] LLR_5,
    output logic [BIT-1:0] LLR_6,
    output logic [BIT-1:0] LLR_7,
    output logic [BIT-1:0] LLR_8
);

    localparam logic [BIT-1:0] C_LLR_POS    = BIT'(LLR_MAG);
    // Two's complement negation keeps the sign bit equal to the channel bit.
    localparam logic [BIT-1:0] C_LLR_NEG    = BIT'(-LLR_MAG);
    localparam logic [1:0]     C_LAST_STAGE = 2'(LOG2N - 1);

    enc_state_t           state_q, state_d;
    logic [N-1:0]         v_q, v_d;
    logic [N-1:0]         mask_q, mask_d;
    logic [1:0]           stage_q, stage_d;
    logic                 en_busy_q, en_busy_d;
    logic                 out_valid_q, out_valid_d;
    logic [N-1:0]         code_q, code_d;
    logic [N-1:0][BIT-1:0] llr_q, llr_d;

    logic [N-1:0]         w_stage_out;

    polar_xor_stage u_xor_stage (
        .i_stage (stage_q),
        .i_v     (v_q),
        .o_v     (w_stage_out)
    );

    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        mask_d      = mask_q;
        stage_d     = stage_q;
        en_busy_d   = en_busy_q;
        out_valid_d = out_valid_q;
        code_d      = code_q;
        llr_d       = llr_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    v_d       = map_info(info);
                    mask_d    = err_mask;
                    en_busy_d = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                stage_d = 2'd0;
                state_d = ST_ENC;
            end
            ST_ENC: begin
                v_d = w_stage_out;
                if (stage_q == C_LAST_STAGE) begin
                    // Final stage result goes straight to the output registers.
                    code_d = w_stage_out;
                    for (int n = 0; n < N; n++) begin
                        llr_d[n] = (w_stage_out[n] ^ mask_q[n]) ? C_LLR_NEG : C_LLR_POS;
                    end
                    out_valid_d = 1'b1;
                    state_d     = ST_VALID;
                end else begin
                    stage_d = stage_q + 2'd1;
                end
            end
            ST_VALID: begin
                // Start is ignored here, even on the handshake cycle.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    en_busy_d   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            v_q         <= '0;
            mask_q      <= '0;
            stage_q     <= 2'd0;
            en_busy_q   <= 1'b0;
            out_valid_q <= 1'b0;
            code_q      <= '0;
            llr_q       <= {N{C_LLR_POS}};
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            mask_q      <= mask_d;
            stage_q     <= stage_d;
            en_busy_q   <= en_busy_d;
            out_valid_q <= out_valid_d;
            code_q      <= code_d;
            llr_q       <= llr_d;
        end
    end

    assign en_busy   = en_busy_q;
    assign out_valid = out_valid_q;
    assign code_out  = code_q;
    assign LLR_1     = llr_q[0];
    assign LLR_2     = llr_q[1];
    assign LLR_3     = llr_q[2];
    assign LLR_4     = llr_q[3];
    assign LLR_5     = llr_q[4];
    assign LLR_6     = llr_q[5];
    assign LLR_7     = llr_q[6];
    assign LLR_8     = llr_q[7];

endmodule
`default_nettype wire

// File: tb/tb_polar_enc_8_4.sv
`default_nettype none
// ============================================================================
//  Module      : tb_polar_enc_8_4
//  Description : Self-checking bench for polar_enc_8_4: reset state, latency,
//                codeword/LLR values, backpressure, reset mid-encode and a
//                sweep of all info values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_polar_enc_8_4;

    localparam logic [7:0] LLR_POS = 8'h40;  // +64
    localparam logic [7:0] LLR_NEG = 8'hC0;  // -64 in 8-bit two's complement

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] info;
    logic [7:0] err_mask;
    logic       out_ready;
    logic       en_busy;
    logic       out_valid;
    logic [7:0] code_out;
    logic [7:0] LLR_1, LLR_2, LLR_3, LLR_4, LLR_5, LLR_6, LLR_7, LLR_8;
    logic [63:0] llr_vec;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_code;
    logic [63:0] exp_llr;

    always #5 clk = ~clk;

    assign llr_vec = {LLR_8, LLR_7, LLR_6, LLR_5, LLR_4, LLR_3, LLR_2, LLR_1};

    polar_enc_8_4 #(.BIT(8), .LLR_MAG(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .info      (info),
        .err_mask  (err_mask),
        .out_ready (out_ready),
        .en_busy   (en_busy),
        .out_valid (out_valid),
        .code_out  (code_out),
        .LLR_1     (LLR_1),
        .LLR_2     (LLR_2),
        .LLR_3     (LLR_3),
        .LLR_4     (LLR_4),
        .LLR_5     (LLR_5),
        .LLR_6     (LLR_6),
        .LLR_7     (LLR_7),
        .LLR_8     (LLR_8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Info placement: info[0]->u3, info[1]->u5, info[2]->u6, info[3]->u7.
    function automatic logic [7:0] place(input logic [3:0] inf);
        logic [7:0] u;
        u = 8'h00;
        u[3] = inf[0];
        u[5] = inf[1];
        u[6] = inf[2];
        u[7] = inf[3];
        return u;
    endfunction

    // x_j = XOR of a_i over every i that is a bit-superset of j.
    function automatic logic [7:0] xform(input logic [7:0] a);
        logic [7:0] x;
        for (int j = 0; j < 8; j++) begin
            x[j] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if ((j & ~i) == 0) x[j] = x[j] ^ a[i];
            end
        end
        return x;
    endfunction

    function automatic logic [7:0] model(input logic [3:0] inf);
        return xform(place(inf));
    endfunction

    function automatic logic [63:0] llr_of(input logic [7:0] ch);
        logic [63:0] r;
        for (int n = 0; n < 8; n++) r[8*n +: 8] = ch[n] ? LLR_NEG : LLR_POS;
        return r;
    endfunction

    // Every cycle the outputs are valid they must match the model.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            check("cmp_code", code_out, exp_code);
            check("cmp_llr", llr_vec, exp_llr);
            check("cmp_busy", en_busy, 1'b1);
        end
    end

    task automatic do_encode(input logic [3:0] inf, input logic [7:0] m, input int hold);
        exp_code  = model(inf);
        exp_llr   = llr_of(model(inf) ^ m);
        info      = inf;
        err_mask  = m;
        start     = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", en_busy, 1'b1);
        check("valid_early", out_valid, 1'b0);
        for (int c = 1; c < 4; c++) begin
            @(posedge clk); #1;
            check("valid_early", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        check("valid_latency", out_valid, 1'b1);
        check("code_at_valid", code_out, exp_code);
        for (int h = 0; h < hold; h++) begin
            start    = 1'b1;
            info     = ~inf;
            err_mask = ~m;
            @(posedge clk); #1;
            check("hold_valid", out_valid, 1'b1);
            check("hold_busy", en_busy, 1'b1);
            check("hold_code", code_out, exp_code);
            check("hold_llr", llr_vec, exp_llr);
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hs_valid_low", out_valid, 1'b0);
        check("hs_busy_low", en_busy, 1'b0);
        @(posedge clk); #1;
        check("idle_stays", en_busy, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        info      = 4'h0;
        err_mask  = 8'h00;
        out_ready = 1'b0;
        exp_code  = 8'h00;
        exp_llr   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", en_busy, 1'b0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_code", code_out, 8'h00);
        check("rst_llr", llr_vec, 64'h4040_4040_4040_4040);
        rst = 1'b0;
        @(posedge clk); #1;

        // Hand-computed pins for the model itself.
        check("pin_m0", model(4'b0000), 8'h00);
        check("pin_m8", model(4'b1000), 8'hFF);
        check("pin_m1", model(4'b0001), 8'h0F);
        check("pin_m2", model(4'b0010), 8'h33);
        check("pin_m4", model(4'b0100), 8'h55);

        do_encode(4'b0000, 8'h00, 0);
        check("lit_code_0", code_out, 8'h00);
        check("lit_llr_0", llr_vec, 64'h4040_4040_4040_4040);

        do_encode(4'b1000, 8'h00, 0);
        check("lit_code_8", code_out, 8'hFF);
        check("lit_llr_8", llr_vec, 64'hC0C0_C0C0_C0C0_C0C0);

        do_encode(4'b0001, 8'h00, 0);
        check("lit_code_1", code_out, 8'h0F);
        check("lit_llr_1", llr_vec, 64'h4040_4040_C0C0_C0C0);

        // Masked bit 0 plus 10 cycles of backpressure with start pulses.
        do_encode(4'b0001, 8'h01, 10);
        check("lit_code_1m", code_out, 8'h0F);
        check("lit_llr_1m", llr_vec, 64'h4040_4040_C0C0_C040);

        // Reset while encoding.
        info     = 4'b1010;
        err_mask = 8'h00;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rstenc_valid", out_valid, 1'b0);
        check("rstenc_busy", en_busy, 1'b0);
        check("rstenc_code", code_out, 8'h00);
        check("rstenc_llr", llr_vec, 64'h4040_4040_4040_4040);
        repeat (5) begin
            @(posedge clk); #1;
            check("rstenc_no_out", out_valid, 1'b0);
        end
        do_encode(4'b0110, 8'h00, 0);
        check("after_rst_code", code_out, model(4'b0110));

        // Sweep: inverse transform of the codeword must recover the info bits.
        for (int v = 0; v < 16; v++) begin
            do_encode(4'(v), 8'h00, 0);
            check("sweep_code", code_out, model(4'(v)));
            check("sweep_decode", xform(code_out), place(4'(v)));
        end
        for (int r = 0; r < 6; r++) begin
            do_encode(4'($urandom_range(15)), 8'($urandom_range(255)), r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
